// File: rtl/serial_demux_ctrl_pkg.sv
// serial_demux_ctrl_pkg: shared FSM state encoding and frame/demux geometry
package serial_demux_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, LEN = 2'd2, DATA = 2'd3} state_t;
  localparam int ADDR_W = 2;
  localparam int NUM_CH = 4;
endpackage

// File: rtl/serial_demux_ctrl_if.sv
// serial_demux_ctrl_if: frame source (start, serial_in) -> controller (sel, dout, dout_valid, busy, frame_done, ovr, chan_cnt)
interface serial_demux_ctrl_if
  import serial_demux_ctrl_pkg::*;
#(parameter int CNT_W = 8);
  logic start;
  logic serial_in;
  logic [ADDR_W-1:0] sel;
  logic dout;
  logic dout_valid;
  logic busy;
  logic frame_done;
  logic ovr;
  logic [NUM_CH*CNT_W-1:0] chan_cnt;
  modport master(output start, serial_in, input sel, dout, dout_valid, busy, frame_done, ovr, chan_cnt);
  modport slave(input start, serial_in, output sel, dout, dout_valid, busy, frame_done, ovr, chan_cnt);
endinterface

// File: rtl/serial_demux_ctrl_chan_frame_counter.sv
// chan_frame_counter: NUM_CH wrapping CNT_W-bit counters, inc bumps counter idx, rst_n clears all synchronously
module chan_frame_counter
  import serial_demux_ctrl_pkg::*;
#(parameter int CNT_W = 8)
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic [ADDR_W-1:0]       idx,
  output logic [NUM_CH*CNT_W-1:0] cnt
);
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (inc) cnt[idx*CNT_W +: CNT_W] <= cnt[idx*CNT_W +: CNT_W] + CNT_W'(1);
endmodule

// File: rtl/serial_demux_ctrl.sv
// serial_demux_ctrl: parses addr/len/payload serial frames into demux sel/dout with per-channel frame counts (clk, rst_n, bus.slave)
module serial_demux_ctrl
  import serial_demux_ctrl_pkg::*;
#(
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
)
(
  input logic                clk,
  input logic                rst_n,
  serial_demux_ctrl_if.slave bus
);
  state_t state_q, state_d;
  logic [LEN_W-1:0] bit_cnt, len_r;
  logic addr_msb, last_bit;
  assign last_bit = (state_q == ADDR && bit_cnt == LEN_W'(ADDR_W - 1)) ||
                    (state_q == LEN  && bit_cnt == LEN_W'(LEN_W - 1)) ||
                    (state_q == DATA && bit_cnt == len_r);
  assign bus.busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = bus.start ? ADDR : IDLE;
      ADDR: state_d = last_bit ? LEN : ADDR;
      LEN:  state_d = last_bit ? DATA : LEN;
      DATA: state_d = last_bit ? IDLE : DATA;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt        <= '0;
      len_r          <= '0;
      addr_msb       <= 1'b0;
      bus.sel        <= '0;
      bus.dout       <= 1'b0;
      bus.dout_valid <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.ovr        <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt        <= (state_q == IDLE || last_bit) ? '0 : bit_cnt + LEN_W'(1);
      addr_msb       <= (state_q == ADDR && !last_bit) ? bus.serial_in : addr_msb;
      bus.sel        <= (state_q == ADDR && last_bit) ? {addr_msb, bus.serial_in} : bus.sel;
      len_r          <= state_q == LEN ? LEN_W'({len_r, bus.serial_in}) : len_r;
      bus.dout       <= state_q == DATA && bus.serial_in;
      bus.dout_valid <= state_q == DATA;
      bus.frame_done <= state_q == DATA && last_bit;
      bus.ovr        <= bus.start && state_q != IDLE;
    end
  end
  chan_frame_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (bus.frame_done),
    .idx  (bus.sel),
    .cnt  (bus.chan_cnt)
  );
endmodule

// File: tb/tb_serial_demux_ctrl.sv
// tb_serial_demux_ctrl: directed frames with hand-computed expectations for serial_demux_ctrl
module tb_serial_demux_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_cnt [4];
  logic [1:0] last_sel;
  serial_demux_ctrl_if #(.CNT_W(8)) bus();
  serial_demux_ctrl #(.LEN_W(4), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] cnt_vec;
    return {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]};
  endfunction
  task automatic check_idle_outputs(input string tag);
    check({tag, "_sel"}, bus.sel, 0);
    check({tag, "_dout"}, {bus.dout_valid, bus.dout}, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_fd"}, bus.frame_done, 0);
    check({tag, "_ovr"}, bus.ovr, 0);
    check({tag, "_cnt"}, bus.chan_cnt, 0);
  endtask
  task automatic frame(input logic [1:0] a, input logic [3:0] l, input logic [15:0] p,
                       input bit ovr_len, input bit ovr_last);
    bus.start = 1'b1;
    bus.serial_in = 1'b0;
    step;
    bus.start = 1'b0;
    check("busy_t1", bus.busy, 1);
    bus.serial_in = a[1];
    step;
    check("sel_hold", bus.sel, last_sel);
    bus.serial_in = a[0];
    step;
    check("sel_t3", bus.sel, a);
    check("gap_dout", {bus.dout_valid, bus.dout}, 0);
    for (int k = 3; k >= 0; k--) begin
      bus.serial_in = l[k];
      bus.start = ovr_len && k == 3;
      step;
      bus.start = 1'b0;
      if (k == 3) check("ovr_len", bus.ovr, ovr_len);
    end
    for (int i = 0; i <= int'(l); i++) begin
      if (i > 0) begin
        check("dv", bus.dout_valid, 1);
        check("dout", bus.dout, p[i-1]);
        check("fd_mid", bus.frame_done, 0);
        check("sel_data", bus.sel, a);
      end
      bus.serial_in = p[i];
      bus.start = ovr_last && i == int'(l);
      step;
      bus.start = 1'b0;
    end
    check("dv_last", bus.dout_valid, 1);
    check("dout_last", bus.dout, p[l]);
    check("fd_last", bus.frame_done, 1);
    check("busy_end", bus.busy, 0);
    check("ovr_last", bus.ovr, ovr_last);
    check("sel_last", bus.sel, a);
    bus.serial_in = 1'b0;
    step;
    exp_cnt[a]++;
    last_sel = a;
    check("post_dout", {bus.dout_valid, bus.dout}, 0);
    check("post_fd", bus.frame_done, 0);
    check("chan_cnt", bus.chan_cnt, cnt_vec());
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    for (int c = 0; c < 4; c++) exp_cnt[c] = '0;
    last_sel = 2'd0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.serial_in = 1'b0;
    step;
    step;
    check_idle_outputs("rst");
    rst_n = 1'b1;
    step;
    frame(2'd2, 4'd3, 16'b1101, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) frame(2'(c), 4'd0, 16'd1 & 16'(c), 1'b0, 1'b0);
    frame(2'd1, 4'd2, 16'b011, 1'b1, 1'b1);
    frame(2'd0, 4'd1, 16'b10, 1'b0, 1'b0);
    frame(2'd3, 4'd15, 16'h5555, 1'b0, 1'b0);
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    bus.serial_in = 1'b1;
    step;
    bus.serial_in = 1'b0;
    step;
    for (int k = 3; k >= 0; k--) begin
      bus.serial_in = k < 2;
      step;
    end
    bus.serial_in = 1'b1;
    step;
    check("mid_dv", bus.dout_valid, 1);
    step;
    rst_n = 1'b0;
    step;
    check_idle_outputs("midrst");
    rst_n = 1'b1;
    bus.serial_in = 1'b0;
    step;
    check_idle_outputs("after_rst");
    for (int c = 0; c < 4; c++) exp_cnt[c] = '0;
    last_sel = 2'd0;
    frame(2'd0, 4'd0, 16'd1, 1'b0, 1'b0);
    frame(2'd3, 4'd1, 16'b01, 1'b0, 1'b0);
    for (int n = 0; n < 256; n++) frame(2'd1, 4'd0, 16'(n & 1), 1'b0, 1'b0);
    check("wrap_cnt", bus.chan_cnt, 32'h0100_0001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_demux_ctrl.md
# serial_demux_ctrl

Frame-parsing controller placed directly upstream of the 1-to-4 demux. It receives a serial bitstream framed as a 2-bit destination address, a length field and a payload. It drives the demux select and data input so each payload bit reaches exactly one of four channels. It also keeps a per-channel count of completed frames for status readback.

## Interface
Parameters:
- LEN_W, 4, width of length field; payload bits per frame = LEN+1 (1..2^LEN_W)
- CNT_W, 8, width of each per-channel frame counter

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  frame start strobe, accepted only in IDLE
- serial_in  in  1  serial frame bit, sampled every cycle
- sel  out  2  demux select, held for whole frame and after it
- dout  out  1  demux data input; 0 whenever dout_valid=0
- dout_valid  out  1  dout carries a payload bit
- busy  out  1  frame in progress (state != IDLE)
- frame_done  out  1  one-cycle pulse, coincident with last dout_valid of a frame
- ovr  out  1  one-cycle pulse: start seen while busy (ignored)
- chan_cnt  out  4*CNT_W  completed-frame counters, channel k at bits [k*CNT_W +: CNT_W]

## Operation
- States: IDLE, ADDR, LEN, DATA.
- IDLE: start=1 -> ADDR. serial_in is ignored on the start cycle.
- ADDR: 2 cycles, address MSB first -> LEN.
  - sel is loaded with the full address on the clock edge that samples the second address bit.
- LEN: LEN_W cycles, MSB first; the value is stored in len_r -> DATA. bit_cnt is cleared.
- DATA: LEN+1 cycles.
  - Each sampled bit is registered to dout with dout_valid=1.
  - On the sample where bit_cnt==len_r -> IDLE.
- frame_done asserts with the last dout_valid.
- chan_cnt[sel] increments on the edge after frame_done. Each counter wraps 2^CNT_W-1 -> 0.
- start while busy: ignored, state unaffected, ovr pulses on the next cycle.
- start in the same cycle DATA samples its last bit: still busy, so ignored with ovr.
- Back-to-back frames: earliest accepted start is the cycle after the last payload bit is sampled.
- sel is not changed by reset-free idling; it keeps the last address until the next frame's address completes.
- Reset (rst_n=0 at an edge, any state): state=IDLE. All outputs and internal registers are cleared, including chan_cnt. A partial frame is dropped with no frame_done and no counter update.

## Timing
- Reset values: sel=0, dout=0, dout_valid=0, busy=0, frame_done=0, ovr=0, chan_cnt=0.
- start accepted at cycle t:
  - address bits sampled at t+1 and t+2; sel valid from t+3.
  - length sampled at t+3..t+2+LEN_W.
  - payload bit i sampled at t+3+LEN_W+i.
- Payload latency: 1 cycle. A bit sampled at cycle c appears on dout/dout_valid during c+1.
- busy: high from t+1 through the cycle sampling the last payload bit.
- Frame length from start to last dout_valid: 3+LEN_W+LEN+1 cycles.
- sel is stable while dout_valid=1, so the demux never glitches a payload bit onto a wrong channel.

## Structure
- Shared package/include holds:
  - state encoding constants (IDLE=0, ADDR=1, LEN=2, DATA=3)
  - ADDR_W=2
  - NUM_CH=4
- Single sub-module chan_frame_counter:
  - NUM_CH counters of CNT_W bits
  - inputs: inc strobe and 2-bit index
  - synchronous active-low clear
- FSM, shift registers and output registers live in the top module.

## Test plan
- Reset mid-frame, asserted during DATA of a channel-2 frame -> next cycle:
  - all outputs 0, chan_cnt all 0
  - no frame_done
  - a fresh frame afterwards works normally
- start, addr=10, len=0011, payload 1,0,1,1 ->
  - sel=2 from t+3
  - dout_valid high 4 cycles with dout 1,0,1,1
  - frame_done on the 4th; chan_cnt[2]=1 next cycle
- Four frames to channels 0,1,2,3 with len=0 ->
  - each chan_cnt=1
  - dout=0 whenever dout_valid=0
  - sel changes only after each address completes
- start pulsed during LEN and on the last DATA sample ->
  - ovr pulses twice, frame unaffected
  - next start in IDLE is accepted
- Max length len=1111, 16 alternating payload bits to channel 3 -> 16 dout_valid cycles in order, frame_done on the last one.
- 256 len=0 frames to channel 1 (CNT_W=8) -> chan_cnt[1] wraps to 0, other counters unchanged.
